// File: rtl/ser_pkg.sv
// Shared constants, state encoding and helpers for the serializer slot scheduler.
package ser_pkg;

  localparam int SER_WIDTH = 16;

  localparam logic [15:0] TRAIN_PATTERN = 16'hA5A5;
  localparam logic [15:0] IDLE_PATTERN  = 16'h0F0F;

  typedef enum logic {
    TRAIN,
    RUN
  } sched_state_e;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(ptr) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ser_slot_scheduler.sv
// Slot scheduler feeding the serializer: training burst after reset, then round-robin
// sharing with idle fill. Optional word statistics via SER_SLOT_SCHED_STATS_EN.
module ser_slot_scheduler
  import ser_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = SER_WIDTH,
  parameter int LOAD_PERIOD = 4,
  parameter int TRAIN_WORDS = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [WIDTH-1:0]             ser_data_o,
  output logic                         ser_load_o,
  output logic [$clog2(NUM_REQ)-1:0]   ser_src_o,
  output logic                         ser_idle_o,
  output logic                         train_done_o
`ifdef SER_SLOT_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_data_words_o,
  output logic [31:0]                  stat_idle_words_o
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOAD_PERIOD);
  localparam int TW = $clog2(TRAIN_WORDS + 1);

  localparam logic [WIDTH-1:0] TRAIN_WORD = WIDTH'(TRAIN_PATTERN);
  localparam logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(IDLE_PATTERN);

  sched_state_e  state;
  logic [CW-1:0] slot_cnt;
  logic [TW-1:0] train_cnt;
  logic [IW-1:0] ptr;

  logic               slot;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               any_grant;

  assign slot = (slot_cnt == CW'(LOAD_PERIOD - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Ready is combinational so a requester raised mid-period is taken in the same slot;
  // rst_i masks it so no handshake can complete in a reset cycle.
  always_comb begin
    req_ready_o = '0;
    if (state == RUN && slot && !rst_i) begin
      req_ready_o = grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= TRAIN;
      slot_cnt     <= '0;
      train_cnt    <= '0;
      ptr          <= '0;
      ser_data_o   <= IDLE_WORD;
      ser_load_o   <= 1'b0;
      ser_src_o    <= '0;
      ser_idle_o   <= 1'b1;
      train_done_o <= 1'b0;
`ifdef SER_SLOT_SCHED_STATS_EN
      stat_data_words_o <= '0;
      stat_idle_words_o <= '0;
`endif
    end else begin
      slot_cnt   <= slot_cnt + CW'(1);
      ser_load_o <= slot;
      if (slot) begin
        case (state)
          TRAIN: begin
            ser_data_o <= TRAIN_WORD;
            ser_idle_o <= 1'b1;
            ser_src_o  <= '0;
            if (train_cnt == TW'(TRAIN_WORDS - 1)) begin
              state <= RUN;
            end else begin
              train_cnt <= train_cnt + TW'(1);
            end
          end
          RUN: begin
            train_done_o <= 1'b1;
            if (any_grant) begin
              ser_data_o <= req_data_i[grant_idx*WIDTH +: WIDTH];
              ser_src_o  <= grant_idx;
              ser_idle_o <= 1'b0;
              ptr        <= IW'(next_index(32'(grant_idx), NUM_REQ));
`ifdef SER_SLOT_SCHED_STATS_EN
              if (stat_data_words_o != '1) stat_data_words_o <= stat_data_words_o + 32'd1;
`endif
            end else begin
              ser_data_o <= IDLE_WORD;
              ser_idle_o <= 1'b1;
`ifdef SER_SLOT_SCHED_STATS_EN
              if (stat_idle_words_o != '1) stat_idle_words_o <= stat_idle_words_o + 32'd1;
`endif
            end
          end
          default: state <= TRAIN;
        endcase
      end
    end
  end

endmodule
